uart_core_param: RTL and testbench

Parametrised, runtime-configurable UART engine for the serial links on the autopilot FPGA: RS232/RS422/RS485 ports to GPS, telemetry radio and servo controllers. One instance drives one external transceiver chip. It supports 5–8 data bits, none/even/odd parity, 1 or 2 stop bits, and LSB- or MSB-first order. The bit period is set in system-clock cycles by a register. Over a single-byte UART it adds:

- a valid/ready transmit handshake
- separate parity, framing and break flags on receive
- RS485 half-duplex driver-enable control with a configurable turnaround guard

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_bit_timer.sv | 26 ++
 rtl/uart_core_param.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART engine: FSM state encodings,
// parity codes and the data-width decode.
package uart_pkg;

  localparam int unsigned MIN_DIV = 4;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_GUARD
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  // 00..11 -> 5..8 data bits
  function automatic logic [3:0] data_bits(input logic [1:0] cfg);
    return 4'(cfg) + 4'd5;
  endfunction

  // 11 is treated like 00: no parity bit on the wire
  function automatic logic parity_on(input logic [1:0] cfg);
    return (cfg == PAR_EVEN) || (cfg == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: cleared on demand, wraps at the terminal
// count, and flags both the terminal count and a second programmable count.
module uart_bit_timer #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] tc_val_i,
  input  logic [DIV_W-1:0] half_val_i,
  output logic             tc_o,
  output logic             half_o
);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)               cnt_q <= '0;
    else if (clr_i || tc_o)   cnt_q <= '0;
    else                      cnt_q <= cnt_q + DIV_W'(1);
  end

  assign tc_o   = (cnt_q == tc_val_i);
  assign half_o = (cnt_q == half_val_i);

endmodule

// File: rtl/uart_core_param.sv
// Runtime-configurable UART: handshaked transmitter with RS485 driver-enable
// guard, and a majority-voting receiver reporting parity/framing/break.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter bit          LSB_FIRST   = 1'b1,
  parameter bit          HALF_DUPLEX = 1'b0,
  parameter int unsigned GUARD_BITS  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       cfg_data_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_busy,
  output logic             tx_done,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             rx_break,
  output logic             ser_tx,
  output logic             ser_de,
  output logic             ser_re_n,
  input  logic             ser_rx
);

  localparam logic [2:0] GUARD_LAST = (GUARD_BITS == 0) ? 3'd0 : 3'(GUARD_BITS - 1);

  function automatic logic [DIV_W-1:0] div_eff(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d;
  endfunction

  // Reorder the byte so the transmitter always shifts out bit 0 first
  function automatic logic [7:0] tx_order(input logic [7:0] d, input logic [2:0] last);
    logic [7:0] o;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) <= last) o[i] = LSB_FIRST ? d[i] : d[last - 3'(i)];
    end
    return o;
  endfunction

  logic [2:0] cfg_last_c;
  logic [7:0] tx_mask_c;
  assign cfg_last_c = 3'(data_bits(cfg_data_bits) - 4'd1);
  assign tx_mask_c  = 8'hFF >> (3'd7 - cfg_last_c);

  // ---------------- transmitter ----------------
  tx_state_e        tx_state_q;
  logic [DIV_W-1:0] tx_div_q;
  logic [2:0]       tx_last_q, tx_cnt_q;
  logic             tx_par_en_q, tx_stop2_q, tx_par_q;
  logic [7:0]       tx_shift_q;
  logic             tx_ready_q, tx_busy_q, tx_done_q, ser_tx_q, ser_de_q;
  logic             tx_tc, tx_pre;

  // Second compare sits one cycle before terminal count to time tx_done
  uart_bit_timer #(.DIV_W(DIV_W)) u_tx_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (tx_state_q == TX_IDLE),
    .tc_val_i   (tx_div_q - DIV_W'(1)),
    .half_val_i (tx_div_q - DIV_W'(2)),
    .tc_o       (tx_tc),
    .half_o     (tx_pre)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_div_q    <= DIV_W'(MIN_DIV);
      tx_last_q   <= 3'd7;
      tx_cnt_q    <= 3'd0;
      tx_par_en_q <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_par_q    <= 1'b0;
      tx_shift_q  <= 8'h00;
      tx_ready_q  <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      ser_tx_q    <= 1'b1;
      ser_de_q    <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_valid && tx_ready_q) begin
            tx_state_q  <= TX_START;
            tx_div_q    <= div_eff(baud_div);
            tx_last_q   <= cfg_last_c;
            tx_par_en_q <= parity_on(cfg_parity);
            tx_stop2_q  <= cfg_stop2;
            tx_shift_q  <= tx_order(tx_data, cfg_last_c);
            tx_par_q    <= (^(tx_data & tx_mask_c)) ^ (cfg_parity == PAR_ODD);
            tx_cnt_q    <= 3'd0;
            tx_ready_q  <= 1'b0;
            tx_busy_q   <= 1'b1;
            ser_tx_q    <= 1'b0;
            ser_de_q    <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_tc) begin
            ser_tx_q   <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_state_q <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_tc) begin
            if (tx_cnt_q == tx_last_q) begin
              tx_cnt_q <= 3'd0;
              if (tx_par_en_q) begin
                ser_tx_q   <= tx_par_q;
                tx_state_q <= TX_PARITY;
              end else begin
                ser_tx_q   <= 1'b1;
                tx_state_q <= TX_STOP;
              end
            end else begin
              tx_cnt_q   <= tx_cnt_q + 3'd1;
              ser_tx_q   <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end
        end
        TX_PARITY: begin
          if (tx_tc) begin
            ser_tx_q   <= 1'b1;
            tx_state_q <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (tx_pre && (tx_cnt_q == {2'b00, tx_stop2_q})) tx_done_q <= 1'b1;
          if (tx_tc) begin
            if (tx_cnt_q == {2'b00, tx_stop2_q}) begin
              tx_cnt_q <= 3'd0;
              if (GUARD_BITS != 0) begin
                tx_state_q <= TX_GUARD;
              end else begin
                tx_state_q <= TX_IDLE;
                tx_ready_q <= 1'b1;
                tx_busy_q  <= 1'b0;
                ser_de_q   <= 1'b0;
              end
            end else begin
              tx_cnt_q <= tx_cnt_q + 3'd1;
            end
          end
        end
        TX_GUARD: begin
          if (tx_tc) begin
            if (tx_cnt_q == GUARD_LAST) begin
              tx_state_q <= TX_IDLE;
              tx_ready_q <= 1'b1;
              tx_busy_q  <= 1'b0;
              ser_de_q   <= 1'b0;
            end else begin
              tx_cnt_q <= tx_cnt_q + 3'd1;
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;
  assign ser_tx   = ser_tx_q;
  assign ser_de   = ser_de_q;
  assign ser_re_n = HALF_DUPLEX ? ser_de_q : 1'b0;

  // ---------------- receiver ----------------
  rx_state_e        rx_state_q;
  logic [1:0]       rx_sync_q;
  logic [2:0]       rx_smp_q;
  logic [DIV_W-1:0] rx_div_q;
  logic [2:0]       rx_last_q, rx_cnt_q, rx_idx_c;
  logic             rx_par_en_q, rx_odd_q, rx_par_acc_q, rx_brk_q, rx_perr_q;
  logic [7:0]       rx_shift_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q, rx_parity_err_q, rx_frame_err_q, rx_break_q;
  logic             rx_maj_c, rx_fall_c, rx_tc, rx_half;

  assign rx_maj_c  = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx_smp_q[2]) |
                     (rx_smp_q[1] & rx_smp_q[2]);
  assign rx_fall_c = rx_smp_q[1] & ~rx_smp_q[0];
  assign rx_idx_c  = LSB_FIRST ? rx_cnt_q : (rx_last_q - rx_cnt_q);

  // Restart at mid-start so later samples land mid-bit
  uart_bit_timer #(.DIV_W(DIV_W)) u_rx_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      ((rx_state_q == RX_IDLE) || ((rx_state_q == RX_START) && rx_half)),
    .tc_val_i   (rx_div_q - DIV_W'(1)),
    .half_val_i (rx_div_q >> 1),
    .tc_o       (rx_tc),
    .half_o     (rx_half)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q      <= RX_IDLE;
      rx_sync_q       <= 2'b11;
      rx_smp_q        <= 3'b111;
      rx_div_q        <= DIV_W'(MIN_DIV);
      rx_last_q       <= 3'd7;
      rx_cnt_q        <= 3'd0;
      rx_par_en_q     <= 1'b0;
      rx_odd_q        <= 1'b0;
      rx_par_acc_q    <= 1'b0;
      rx_brk_q        <= 1'b0;
      rx_perr_q       <= 1'b0;
      rx_shift_q      <= 8'h00;
      rx_data_q       <= 8'h00;
      rx_valid_q      <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_break_q      <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], ser_rx};
      rx_smp_q   <= {rx_smp_q[1:0], rx_sync_q[1]};
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall_c && !(HALF_DUPLEX && ser_de_q)) begin
            rx_state_q   <= RX_START;
            rx_div_q     <= div_eff(baud_div);
            rx_last_q    <= cfg_last_c;
            rx_par_en_q  <= parity_on(cfg_parity);
            rx_odd_q     <= (cfg_parity == PAR_ODD);
            rx_cnt_q     <= 3'd0;
            rx_shift_q   <= 8'h00;
            rx_par_acc_q <= 1'b0;
            rx_brk_q     <= 1'b1;
            rx_perr_q    <= 1'b0;
          end
        end
        RX_START: begin
          if (rx_half) rx_state_q <= rx_maj_c ? RX_IDLE : RX_DATA;
        end
        RX_DATA: begin
          if (rx_tc) begin
            rx_shift_q[rx_idx_c] <= rx_maj_c;
            rx_par_acc_q         <= rx_par_acc_q ^ rx_maj_c;
            rx_brk_q             <= rx_brk_q & ~rx_maj_c;
            if (rx_cnt_q == rx_last_q) begin
              rx_cnt_q   <= 3'd0;
              rx_state_q <= rx_par_en_q ? RX_PARITY : RX_STOP;
            end else begin
              rx_cnt_q <= rx_cnt_q + 3'd1;
            end
          end
        end
        RX_PARITY: begin
          if (rx_tc) begin
            rx_perr_q  <= rx_maj_c ^ rx_par_acc_q ^ rx_odd_q;
            rx_brk_q   <= rx_brk_q & ~rx_maj_c;
            rx_state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_tc) begin
            rx_valid_q      <= 1'b1;
            rx_data_q       <= rx_shift_q;
            rx_parity_err_q <= rx_perr_q;
            rx_frame_err_q  <= ~rx_maj_c;
            rx_break_q      <= rx_brk_q & ~rx_maj_c;
            rx_state_q      <= rx_maj_c ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_maj_c) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_parity_err_q;
  assign rx_frame_err  = rx_frame_err_q;
  assign rx_break      = rx_break_q;

endmodule

// File: tb/tb_uart_core_param.sv
// Self-checking bench for uart_core_param: table-driven TX/RX vectors with a
// receive scoreboard, plus break, glitch, loopback and mid-frame reset cases.
module tb_uart_core_param;

  localparam int G = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_div;
  logic [1:0]  cfg_data_bits, cfg_parity;
  logic        cfg_stop2;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready, tx_busy, tx_done;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_parity_err, rx_frame_err, rx_break;
  logic        ser_tx, ser_de, ser_re_n, ser_rx;
  logic        rx_drv, loopback;

  assign ser_rx = loopback ? ser_tx : rx_drv;

  always #5 clk = ~clk;

  uart_core_param #(.DIV_W(16), .LSB_FIRST(1'b1), .HALF_DUPLEX(1'b0), .GUARD_BITS(G)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_break(rx_break), .ser_tx(ser_tx), .ser_de(ser_de), .ser_re_n(ser_re_n), .ser_rx(ser_rx)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       perr, ferr, brk;
  } rx_exp_t;

  typedef struct {
    logic [1:0] db, par;
    logic       s2;
    logic [7:0] d;
    logic       flip, bad_stop;
    logic [7:0] exp_d;
    logic       exp_perr, exp_ferr, exp_brk;
  } rx_vec_t;

  typedef struct {
    logic [1:0] db, par;
    logic       s2;
    logic [7:0] d;
    int         div;
  } tx_vec_t;

  rx_exp_t sb[$];
  rx_exp_t mon_e;
  rx_vec_t rxv[8];
  tx_vec_t txv[4];
  int n_vec = 0, n_err = 0, rx_cnt = 0, done_cnt = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
    end
  endfunction

  // Reference wire image of one frame (LSB first)
  function automatic void build(input logic [7:0] d, input int nb, input logic [1:0] par,
                                input logic s2, input logic flip, input logic bad_stop,
                                output logic [11:0] f, output int len);
    logic p;
    f = '1; f[0] = 1'b0; p = 1'b0; len = 1;
    for (int i = 0; i < nb; i++) begin
      f[4'(len)] = d[i]; p ^= d[i]; len++;
    end
    if (par == 2'b01 || par == 2'b10) begin
      f[4'(len)] = p ^ (par == 2'b10) ^ flip; len++;
    end
    f[4'(len)] = ~bad_stop; len++;
    if (s2) begin f[4'(len)] = 1'b1; len++; end
  endfunction

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (rst_n && rx_valid) begin
      rx_cnt++;
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rx_unexpected: got frame data %0h, required no frame", rx_data);
      end else begin
        mon_e = sb.pop_front();
        chk("rx_data", 32'(rx_data), 32'(mon_e.d));
        chk("rx_parity_err", 32'(rx_parity_err), 32'(mon_e.perr));
        chk("rx_frame_err", 32'(rx_frame_err), 32'(mon_e.ferr));
        chk("rx_break", 32'(rx_break), 32'(mon_e.brk));
      end
    end
  end

  task automatic goto(inout int cur, input int idx);
    while (cur < idx) begin @(negedge clk); cur++; end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 5000) begin @(negedge clk); t++; end
    chk("rx_drain_pending", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic tx_send(input logic [1:0] db, input logic [1:0] par, input logic s2,
                         input logic [7:0] d, input int div);
    logic [11:0] f;
    int len, de, cur, t, dc0;
    de = (div < 4) ? 4 : div;
    build(d, int'(db) + 5, par, s2, 1'b0, 1'b0, f, len);
    @(negedge clk);
    cfg_data_bits = db; cfg_parity = par; cfg_stop2 = s2;
    baud_div = 16'(div); tx_data = d;
    t = 0;
    while (!tx_ready && t < 20000) begin @(negedge clk); t++; end
    chk("tx_ready_wait", 32'(tx_ready), 32'd1);
    dc0 = done_cnt;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    cur = 0;
    chk("tx_start_edge", 32'(ser_tx), 32'd0);
    chk("tx_ready_drop", 32'(tx_ready), 32'd0);
    chk("tx_busy_set", 32'(tx_busy), 32'd1);
    for (int k = 0; k < len; k++) begin
      goto(cur, k * de + de / 2);
      chk($sformatf("tx_bit%0d", k), 32'(ser_tx), 32'(f[4'(k)]));
      chk("tx_de_frame", 32'(ser_de), 32'd1);
    end
    goto(cur, len * de - 1);
    chk("tx_done_pulse", 32'(tx_done), 32'd1);
    goto(cur, len * de);
    chk("tx_done_clear", 32'(tx_done), 32'd0);
    chk("tx_guard_line", 32'(ser_tx), 32'd1);
    chk("tx_guard_de", 32'(ser_de), 32'd1);
    goto(cur, (len + G) * de - 1);
    chk("tx_guard_end_de", 32'(ser_de), 32'd1);
    chk("tx_guard_ready", 32'(tx_ready), 32'd0);
    goto(cur, (len + G) * de);
    chk("tx_de_release", 32'(ser_de), 32'd0);
    chk("tx_ready_rise", 32'(tx_ready), 32'd1);
    chk("tx_busy_clear", 32'(tx_busy), 32'd0);
    chk("tx_done_count", 32'(done_cnt - dc0), 32'd1);
  endtask

  task automatic rx_frame(input rx_vec_t v);
    logic [11:0] f;
    int len;
    build(v.d, int'(v.db) + 5, v.par, v.s2, v.flip, v.bad_stop, f, len);
    @(negedge clk);
    cfg_data_bits = v.db; cfg_parity = v.par; cfg_stop2 = v.s2; baud_div = 16'd16;
    sb.push_back('{d: v.exp_d, perr: v.exp_perr, ferr: v.exp_ferr, brk: v.exp_brk});
    for (int k = 0; k < len; k++) begin
      rx_drv = f[4'(k)];
      repeat (16) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (32) @(negedge clk);
    wait_drain();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int c0;
    rxv[0] = '{2'd3, 2'b00, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    rxv[1] = '{2'd3, 2'b10, 1'b0, 8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
    rxv[2] = '{2'd0, 2'b01, 1'b0, 8'h1F, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0};
    rxv[3] = '{2'd1, 2'b00, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0};
    rxv[4] = '{2'd2, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    rxv[5] = '{2'd3, 2'b01, 1'b0, 8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0};
    rxv[6] = '{2'd3, 2'b00, 1'b0, 8'h0F, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0};
    rxv[7] = '{2'd3, 2'b11, 1'b0, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0};
    txv[0] = '{2'd3, 2'b00, 1'b0, 8'hA5, 434};
    txv[1] = '{2'd0, 2'b10, 1'b1, 8'h13, 3};
    txv[2] = '{2'd1, 2'b01, 1'b0, 8'hEA, 10};
    txv[3] = '{2'd2, 2'b11, 1'b0, 8'h7F, 8};

    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_drv = 1'b1; loopback = 1'b0;
    baud_div = 16'd16; cfg_data_bits = 2'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("rst_tx_done", 32'(tx_done), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_flags", 32'({rx_parity_err, rx_frame_err, rx_break}), 32'd0);
    chk("rst_ser_tx", 32'(ser_tx), 32'd1);
    chk("rst_ser_de", 32'(ser_de), 32'd0);
    chk("rst_ser_re_n", 32'(ser_re_n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) tx_send(txv[i].db, txv[i].par, txv[i].s2, txv[i].d, txv[i].div);
    for (int i = 0; i < 8; i++) rx_frame(rxv[i]);

    // 7E2 loopback
    sb.push_back('{d: 8'h3C, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
    loopback = 1'b1;
    tx_send(2'd2, 2'b01, 1'b1, 8'h3C, 16);
    wait_drain();
    loopback = 1'b0;

    // Line held low for 20 bit periods: one break frame, then silence
    @(negedge clk);
    cfg_data_bits = 2'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0; baud_div = 16'd16;
    sb.push_back('{d: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
    c0 = rx_cnt;
    rx_drv = 1'b0;
    repeat (320) @(negedge clk);
    chk("break_single_frame", 32'(rx_cnt - c0), 32'd1);
    rx_drv = 1'b1;
    repeat (48) @(negedge clk);
    wait_drain();

    // Two-cycle glitch at baud_div=100 must be rejected
    baud_div = 16'd100;
    c0 = rx_cnt;
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_no_frame", 32'(rx_cnt - c0), 32'd0);
    rx_frame(rxv[2]);

    // Reset in the middle of DATA
    @(negedge clk);
    cfg_data_bits = 2'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0; baud_div = 16'd16;
    tx_data = 8'h5A; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ser_tx", 32'(ser_tx), 32'd1);
    chk("midrst_ser_de", 32'(ser_de), 32'd0);
    chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
    chk("midrst_tx_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_send(2'd3, 2'b00, 1'b0, 8'h96, 16);

    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
